dial_solver: RTL and testbench

DIAL_SOLVER -- requirements
Module: dial_solver

---
 rtl/dial_solver.sv | 178 +++++++++++++++++
 tb/tb_dial_solver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dial_solver.sv
// Dial solver: parses an L/R rotation command stream from a byte ROM and counts zero hits.
// Optional DIAL_CHUNK_EN: rotate a whole revolution per cycle instead of one click per cycle.
module dial_solver #(
    parameter int DIAL_SIZE = 100,
    parameter int START_POS = 50,
    parameter int ADDR_W    = 15,
    parameter int DIST_W    = 16,
    parameter int COUNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         mode,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [7:0]                   rom_q,
    output logic [COUNT_W-1:0]           result,
    output logic [$clog2(DIAL_SIZE)-1:0] position,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);
    localparam int POS_W = $clog2(DIAL_SIZE);
    localparam logic [POS_W:0] DS_P = (POS_W+1)'(DIAL_SIZE);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DIR, S_DIGIT, S_ROTATE, S_DONE, S_ERROR} state_t;
    state_t state, ret_state;

    logic              dir_left;
    logic              mode_q;
    logic [DIST_W-1:0] acc;

    // Decimal accumulate in a widened word so overflow past DIST_W is visible.
    logic [DIST_W+3:0] acc_next;
    logic              acc_ovf;
    logic              addr_last;
    logic              is_digit;

    assign acc_next  = ({4'b0, acc} * (DIST_W+4)'(10)) + (DIST_W+4)'(rom_q[3:0]);
    assign acc_ovf   = |acc_next[DIST_W+3:DIST_W];
    assign addr_last = &rom_addr;
    assign is_digit  = (rom_q >= 8'h30) && (rom_q <= 8'h39);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + COUNT_W'(1);
    endfunction

`ifdef DIAL_CHUNK_EN
    localparam logic [31:0] DS32 = DIAL_SIZE;
    logic [31:0]      acc32;
    logic [POS_W-1:0] r;
    logic [POS_W:0]   pos_sum;
    logic [POS_W-1:0] rot_pos;
    logic             rot_hit;

    assign acc32 = 32'(acc);

    // Residual move (r < DIAL_SIZE) resolved in one cycle.
    always_comb begin
        r       = POS_W'(acc);
        pos_sum = {1'b0, position} + {1'b0, r};
        rot_pos = position;
        rot_hit = 1'b0;
        if (!dir_left) begin
            if (pos_sum >= DS_P) begin
                rot_pos = POS_W'(pos_sum - DS_P);
                rot_hit = 1'b1;
            end else begin
                rot_pos = POS_W'(pos_sum);
            end
        end else begin
            rot_hit = (r >= position) && (position != '0);
            if (r > position) rot_pos = POS_W'({1'b0, position} + DS_P - {1'b0, r});
            else              rot_pos = position - r;
        end
    end
`else
    logic [POS_W-1:0] step_pos;

    always_comb begin
        step_pos = position;
        if (!dir_left) step_pos = ({1'b0, position} == DS_P - 1'b1) ? '0 : position + 1'b1;
        else           step_pos = (position == '0) ? POS_W'(DS_P - 1'b1) : position - 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            ret_state <= S_DIR;
            rom_addr  <= '0;
            result    <= '0;
            position  <= POS_W'(START_POS);
            acc       <= '0;
            dir_left  <= 1'b0;
            mode_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state     <= S_WAIT;
                        ret_state <= S_DIR;
                        rom_addr  <= '0;
                        result    <= '0;
                        position  <= POS_W'(START_POS);
                        acc       <= '0;
                        mode_q    <= mode;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                S_WAIT: state <= ret_state;
                S_DIR: begin
                    if ((rom_q == 8'h4C || rom_q == 8'h52) && !addr_last) begin
                        dir_left  <= (rom_q == 8'h4C);
                        rom_addr  <= rom_addr + 1'b1;
                        state     <= S_WAIT;
                        ret_state <= S_DIGIT;
                    end else if (rom_q == 8'h00) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end
                end
                S_DIGIT: begin
                    if (addr_last || (is_digit && acc_ovf) ||
                        !(is_digit || rom_q == 8'h0D || rom_q == 8'h0A)) begin
                        state <= S_ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        if (rom_q == 8'h0A) begin
                            state <= S_ROTATE;
                        end else begin
                            if (is_digit) acc <= acc_next[DIST_W-1:0];
                            state     <= S_WAIT;
                            ret_state <= S_DIGIT;
                        end
                    end
                end
                S_ROTATE: begin
`ifdef DIAL_CHUNK_EN
                    if (acc32 >= DS32) begin
                        if (mode_q) result <= sat_inc(result);
                        acc <= acc - DIST_W'(DIAL_SIZE);
                    end else begin
                        position <= rot_pos;
                        if ((mode_q && rot_hit) || (!mode_q && rot_pos == '0))
                            result <= sat_inc(result);
                        acc       <= '0;
                        state     <= S_WAIT;
                        ret_state <= S_DIR;
                    end
`else
                    if (acc != '0) begin
                        position <= step_pos;
                        acc      <= acc - 1'b1;
                        if (mode_q && step_pos == '0) result <= sat_inc(result);
                    end else begin
                        if (!mode_q && position == '0) result <= sat_inc(result);
                        state     <= S_WAIT;
                        ret_state <= S_DIR;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dial_solver.sv
// Directed self-checking bench for dial_solver with a synchronous byte ROM model.
module tb_dial_solver;
    localparam int ADDR_W  = 6;
    localparam int COUNT_W = 4;

    logic                clk = 0;
    logic                resetn = 0;
    logic                start = 0;
    logic                mode = 0;
    logic [ADDR_W-1:0]   rom_addr;
    logic [7:0]          rom_q;
    logic [COUNT_W-1:0]  result;
    logic [6:0]          position;
    logic                busy, done, error;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int checks = 0;
    int errors = 0;

    dial_solver #(.DIAL_SIZE(100), .START_POS(50), .ADDR_W(ADDR_W), .DIST_W(16), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .mode(mode), .rom_addr(rom_addr), .rom_q(rom_q),
        .result(result), .position(position), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) rom_q <= mem[rom_addr];

    task automatic load_rom(input string s);
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) mem[i] = s[i];
    endtask

    task automatic run(input logic m);
        int n;
        mode = m; start = 1;
        @(negedge clk);
        start = 0; mode = 0;
        n = 0;
        while (!(done || error) && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (!(done || error)) begin errors++; $display("FAIL run_timeout: done=%0d error=%0d after %0d cycles", done, error, n); end
    endtask

    task automatic test_reset;
        checks += 6;
        if (result !== 4'd0)     begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        if (position !== 7'd50)  begin errors++; $display("FAIL reset_position: got %0d want 50", position); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
        if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %0d want 0", done); end
        if (error !== 1'b0)      begin errors++; $display("FAIL reset_error: got %0d want 0", error); end
        if (rom_addr !== 6'd0)   begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    endtask

    task automatic test_example;
        load_rom("L68\nL30\nR48\nL5\nR60\nL55\nL1\nL99\nR14\nL82\n");
        run(1'b0);
        checks += 4;
        if (done !== 1'b1)      begin errors++; $display("FAIL ex_m0_done: got %0d want 1", done); end
        if (error !== 1'b0)     begin errors++; $display("FAIL ex_m0_error: got %0d want 0", error); end
        if (result !== 4'd3)    begin errors++; $display("FAIL ex_m0_result: got %0d want 3", result); end
        if (position !== 7'd32) begin errors++; $display("FAIL ex_m0_position: got %0d want 32", position); end
        run(1'b1);
        checks += 2;
        if (result !== 4'd6)    begin errors++; $display("FAIL ex_m1_result: got %0d want 6", result); end
        if (position !== 7'd32) begin errors++; $display("FAIL ex_m1_position: got %0d want 32", position); end
    endtask

    task automatic test_revolutions;
        load_rom("R1000\n");
        run(1'b1);
        checks += 2;
        if (result !== 4'd10)   begin errors++; $display("FAIL rev_m1_result: got %0d want 10", result); end
        if (position !== 7'd50) begin errors++; $display("FAIL rev_m1_position: got %0d want 50", position); end
        run(1'b0);
        checks++;
        if (result !== 4'd0)    begin errors++; $display("FAIL rev_m0_result: got %0d want 0", result); end
    endtask

    task automatic test_parse_error;
        load_rom("L50\nX");
        run(1'b0);
        checks += 4;
        if (error !== 1'b1)  begin errors++; $display("FAIL perr_error: got %0d want 1", error); end
        if (done !== 1'b0)   begin errors++; $display("FAIL perr_done: got %0d want 0", done); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL perr_busy: got %0d want 0", busy); end
        if (result !== 4'd1) begin errors++; $display("FAIL perr_result: got %0d want 1", result); end
    endtask

    task automatic test_empty;
        load_rom("");
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        checks += 3;
        if (done !== 1'b1)      begin errors++; $display("FAIL empty_done: got %0d want 1", done); end
        if (result !== 4'd0)    begin errors++; $display("FAIL empty_result: got %0d want 0", result); end
        if (position !== 7'd50) begin errors++; $display("FAIL empty_position: got %0d want 50", position); end
    endtask

    task automatic test_no_digits;
        load_rom("L50\nR\n");
        run(1'b0);
        checks++;
        if (result !== 4'd2)   begin errors++; $display("FAIL nodig_m0_result: got %0d want 2", result); end
        run(1'b1);
        checks += 2;
        if (result !== 4'd1)   begin errors++; $display("FAIL nodig_m1_result: got %0d want 1", result); end
        if (position !== 7'd0) begin errors++; $display("FAIL nodig_m1_position: got %0d want 0", position); end
    endtask

    task automatic test_left_from_zero;
        load_rom("L50\nL5\n");
        run(1'b1);
        checks += 2;
        if (result !== 4'd1)    begin errors++; $display("FAIL lzero_result: got %0d want 1", result); end
        if (position !== 7'd95) begin errors++; $display("FAIL lzero_position: got %0d want 95", position); end
    endtask

    task automatic test_saturate;
        load_rom("R2000\n");
        run(1'b1);
        checks += 2;
        if (result !== 4'd15)   begin errors++; $display("FAIL sat_result: got %0d want 15", result); end
        if (position !== 7'd50) begin errors++; $display("FAIL sat_position: got %0d want 50", position); end
    endtask

    task automatic test_overflow;
        load_rom("R70000\n");
        run(1'b0);
        checks += 2;
        if (error !== 1'b1) begin errors++; $display("FAIL acc_ovf_error: got %0d want 1", error); end
        if (done !== 1'b0)  begin errors++; $display("FAIL acc_ovf_done: got %0d want 0", done); end
        load_rom("R");
        for (int i = 1; i < (1 << ADDR_W); i++) mem[i] = 8'h0D;
        run(1'b0);
        checks += 2;
        if (error !== 1'b1) begin errors++; $display("FAIL addr_ovf_error: got %0d want 1", error); end
        if (done !== 1'b0)  begin errors++; $display("FAIL addr_ovf_done: got %0d want 0", done); end
    endtask

    task automatic test_back_to_back;
        load_rom("R1000\n");
        mode = 1; start = 1;
        @(negedge clk);
        start = 0; mode = 0;
        repeat (5) @(negedge clk);
        mode = 0; start = 1;
        @(negedge clk);
        start = 0;
        for (int n = 0; n < 5000 && !(done || error); n++) @(negedge clk);
        checks += 2;
        if (done !== 1'b1)    begin errors++; $display("FAIL b2b_done: got %0d want 1", done); end
        if (result !== 4'd10) begin errors++; $display("FAIL b2b_result: got %0d want 10", result); end
    endtask

    task automatic test_reset_mid;
        load_rom("R1000\n");
        mode = 1; start = 1;
        @(negedge clk);
        start = 0; mode = 0;
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0d want 1", busy); end
        resetn = 0;
        #1;
        test_reset();
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        run(1'b1);
        checks += 2;
        if (result !== 4'd10)   begin errors++; $display("FAIL mid_rerun_result: got %0d want 10", result); end
        if (position !== 7'd50) begin errors++; $display("FAIL mid_rerun_position: got %0d want 50", position); end
    endtask

    initial begin
        load_rom("");
        resetn = 0;
        repeat (3) @(negedge clk);
        test_reset();
        resetn = 1;
        @(negedge clk);
        test_reset();
        test_example();
        test_revolutions();
        test_parse_error();
        test_empty();
        test_no_digits();
        test_left_from_zero();
        test_saturate();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
